// File: rtl/legv8_pkg.sv
// -----------------------------------------------------------------------------
// legv8_pkg
// Shared definitions for the LEGv8 issue-stage register scoreboard.
//   NREGS     : number of architectural registers
//   reg_idx_t : architectural register index
//   REG_XZR   : X31/XZR, which is never tracked by the scoreboard
//   is_tracked: true for any register the scoreboard keeps a count for
// -----------------------------------------------------------------------------
package legv8_pkg;

   localparam int NREGS = 32;

   typedef logic [4:0] reg_idx_t;

   localparam reg_idx_t REG_XZR = 5'd31;

   function automatic logic is_tracked(input reg_idx_t idx);
      return (idx != REG_XZR);
   endfunction

endpackage

// File: rtl/sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
// Pending-writer counter for one architectural register.
// Ports:
//   clk, reset : clock and synchronous active-high clear
//   inc        : one new writer was accepted for this register
//   dec_a      : one writer retires (writeback) this cycle
//   dec_b      : one writer is squashed this cycle
//   cnt        : registered count of in-flight writers
//   eff        : count after this cycle's decrements (drives hazard checks)
//   underflow  : a decrement found no writer to remove; it is dropped
// -----------------------------------------------------------------------------
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec_a,
   input  logic             dec_b,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] eff,
   output logic             underflow
);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] next_s;
   logic [CNT_W:0]   req_s;

   // Remove this cycle's retire/kill reports, clamping at zero so excess reports
   // never wrap the count. eff must not depend on inc: inc is derived from the
   // stall decision that eff feeds.
   always_comb begin
      req_s = {{CNT_W{1'b0}}, dec_a} + {{CNT_W{1'b0}}, dec_b};
      if (req_s > {1'b0, cnt_r}) begin
         underflow = 1'b1;
         eff       = {CNT_W{1'b0}};
      end else begin
         underflow = 1'b0;
         eff       = cnt_r - req_s[CNT_W-1:0];
      end
   end

   // Add the newly accepted writer; the saturation stall upstream keeps this
   // from exceeding the all-ones value.
   always_comb begin
      if (inc) begin
         next_s = eff + CNT_W'(1'b1);
      end else begin
         next_s = eff;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= next_s;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Issue-stage scoreboard for the LEGv8 32x64 register file. Counts in-flight
// writers per register and holds decode on read-after-write hazards that the
// register file's same-cycle write-to-read bypass cannot cover, and on
// writer-count saturation. X31/XZR is never tracked.
// Ports:
//   clk, reset            : clock, synchronous active-high clear
//   issue_valid           : decode presents an instruction
//   issue_ra1/_use1       : source 1 index and read enable
//   issue_ra2/_use2       : source 2 index and read enable
//   issue_we/_wa          : destination write enable and index
//   wb_valid/wb_wa        : a writer retires this cycle
//   kill_valid/kill_wa    : a squashed writer is reported this cycle
//   stall                 : combinational hold for decode
//   issue_accept          : combinational issue_valid & ~stall
//   pending               : per-register "writers in flight", registered view
//   err                   : sticky protocol-error flag (unmatched retire/kill)
// -----------------------------------------------------------------------------
module regfile_scoreboard
   import legv8_pkg::*;
#(
   parameter int CNT_W = 2,
   parameter int NREGS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic [4:0]       issue_ra1,
   input  logic             issue_use1,
   input  logic [4:0]       issue_ra2,
   input  logic             issue_use2,
   input  logic             issue_we,
   input  logic [4:0]       issue_wa,
   input  logic             wb_valid,
   input  logic [4:0]       wb_wa,
   input  logic             kill_valid,
   input  logic [4:0]       kill_wa,
   output logic             stall,
   output logic             issue_accept,
   output logic [NREGS-1:0] pending,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   // Entry NREGS-1 (XZR) is tied to zero so the source muxes can index freely.
   logic [CNT_W-1:0] eff_s [NREGS];
   logic [NREGS-2:0] inc_s;
   logic [NREGS-2:0] wb_dec_s;
   logic [NREGS-2:0] kill_dec_s;
   logic [NREGS-2:0] underflow_s;
   logic             h1_s;
   logic             h2_s;
   logic             hs_s;
   logic             stall_s;
   logic             err_r;

   for (genvar r = 0; r < NREGS - 1; r++) begin : g_reg
      logic [CNT_W-1:0] cnt_l;

      assign inc_s[r]      = issue_accept & issue_we   & (issue_wa == reg_idx_t'(r));
      assign wb_dec_s[r]   = wb_valid                  & (wb_wa    == reg_idx_t'(r));
      assign kill_dec_s[r] = kill_valid                & (kill_wa  == reg_idx_t'(r));

      sb_counter #(
         .CNT_W(CNT_W)
      ) u_cnt (
         .clk      (clk),
         .reset    (reset),
         .inc      (inc_s[r]),
         .dec_a    (wb_dec_s[r]),
         .dec_b    (kill_dec_s[r]),
         .cnt      (cnt_l),
         .eff      (eff_s[r]),
         .underflow(underflow_s[r])
      );

      assign pending[r] = (cnt_l != CNT_ZERO);
   end

   assign eff_s[NREGS-1]   = CNT_ZERO;
   assign pending[NREGS-1] = 1'b0;

   // Hazard detection against post-retire counts, so a writer retiring this
   // cycle is satisfied by the register-file bypass and does not stall.
   always_comb begin
      h1_s    = issue_use1 & is_tracked(issue_ra1) & (eff_s[issue_ra1] != CNT_ZERO);
      h2_s    = issue_use2 & is_tracked(issue_ra2) & (eff_s[issue_ra2] != CNT_ZERO);
      hs_s    = issue_we   & is_tracked(issue_wa)  & (eff_s[issue_wa]  == CNT_MAX);
      stall_s = issue_valid & (h1_s | h2_s | hs_s);
   end

   assign stall        = stall_s;
   assign issue_accept = issue_valid & ~stall_s;

   // Sticky error: any retire/kill report that found no writer to remove.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if (|underflow_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign err = err_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

   localparam int CNT_W = 2;
   localparam int CMAX  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_ra1;
   logic        issue_use1;
   logic [4:0]  issue_ra2;
   logic        issue_use2;
   logic        issue_we;
   logic [4:0]  issue_wa;
   logic        wb_valid;
   logic [4:0]  wb_wa;
   logic        kill_valid;
   logic [4:0]  kill_wa;
   logic        stall;
   logic        issue_accept;
   logic [31:0] pending;
   logic        err;

   typedef struct packed {
      logic        stall;
      logic        accept;
      logic [31:0] pending;
      logic        err;
   } resp_t;

   resp_t exp_q[$];
   resp_t obs_q[$];
   int    vectors     = 0;
   int    miscompares = 0;
   int    m_cnt [32];
   logic  m_err;

   regfile_scoreboard #(.CNT_W(CNT_W), .NREGS(32)) dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid),
      .issue_ra1(issue_ra1), .issue_use1(issue_use1),
      .issue_ra2(issue_ra2), .issue_use2(issue_use2),
      .issue_we(issue_we), .issue_wa(issue_wa),
      .wb_valid(wb_valid), .wb_wa(wb_wa),
      .kill_valid(kill_valid), .kill_wa(kill_wa),
      .stall(stall), .issue_accept(issue_accept),
      .pending(pending), .err(err)
   );

   always #5 clk = ~clk;

   function automatic int m_eff(input int r, input logic wv, input int wwa,
                                input logic kv, input int kwa);
      int e;
      e = m_cnt[r];
      if (wv && wwa == r) e = e - 1;
      if (kv && kwa == r) e = e - 1;
      if (e < 0) e = 0;
      return e;
   endfunction

   // One clock of stimulus: the model predicts the response and pushes it,
   // the DUT's observed response is pushed alongside it.
   task automatic cycle(input logic rst = 1'b0, input logic iv = 1'b0,
                        input int ra1 = 0, input logic u1 = 1'b0,
                        input int ra2 = 0, input logic u2 = 1'b0,
                        input logic we = 1'b0, input int wa = 0,
                        input logic wv = 1'b0, input int wwa = 0,
                        input logic kv = 1'b0, input int kwa = 0);
      resp_t e;
      resp_t o;
      int    d;
      reset = rst; issue_valid = iv;
      issue_ra1 = 5'(ra1); issue_use1 = u1;
      issue_ra2 = 5'(ra2); issue_use2 = u2;
      issue_we = we; issue_wa = 5'(wa);
      wb_valid = wv; wb_wa = 5'(wwa);
      kill_valid = kv; kill_wa = 5'(kwa);
      e.stall = iv && ((u1 && ra1 != 31 && m_eff(ra1, wv, wwa, kv, kwa) != 0) ||
                       (u2 && ra2 != 31 && m_eff(ra2, wv, wwa, kv, kwa) != 0) ||
                       (we && wa != 31 && m_eff(wa, wv, wwa, kv, kwa) == CMAX));
      e.accept = iv && !e.stall;
      if (rst) begin
         for (int r = 0; r < 32; r++) m_cnt[r] = 0;
         m_err = 1'b0;
      end else begin
         for (int r = 0; r < 31; r++) begin
            d = 0;
            if (wv && wwa == r) d = d + 1;
            if (kv && kwa == r) d = d + 1;
            if (d > m_cnt[r]) begin
               m_err = 1'b1;
               d = m_cnt[r];
            end
            m_cnt[r] = m_cnt[r] - d + ((e.accept && we && wa == r) ? 1 : 0);
         end
      end
      e.pending = 32'h0;
      for (int r = 0; r < 32; r++) e.pending[r] = (m_cnt[r] != 0);
      e.err = m_err;
      exp_q.push_back(e);
      #3;
      o.stall  = stall;
      o.accept = issue_accept;
      @(posedge clk);
      #1;
      o.pending = pending;
      o.err     = err;
      obs_q.push_back(o);
   endtask

   task automatic test_reset();
      resp_t e, o;
      cycle(.rst(1'b1));
      cycle(.rst(1'b1), .iv(1'b1), .ra1(2), .u1(1'b1));
      cycle();
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL reset: got stall=%b acc=%b pend=%h err=%b, want stall=%b acc=%b pend=%h err=%b",
                     o.stall, o.accept, o.pending, o.err, e.stall, e.accept, e.pending, e.err);
         end
      end
   endtask

   task automatic test_raw();
      resp_t e, o;
      cycle(.iv(1'b1), .ra1(3), .u1(1'b1), .we(1'b1), .wa(5));
      cycle(.iv(1'b1), .ra1(5), .u1(1'b1));
      cycle(.iv(1'b1), .ra2(5), .u2(1'b1));
      cycle(.iv(1'b1), .ra1(5), .u1(1'b1), .wv(1'b1), .wwa(5));
      cycle(.iv(1'b1), .ra1(5), .u1(1'b1), .ra2(5), .u2(1'b1));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL raw_bypass: got stall=%b acc=%b pend=%h err=%b, want stall=%b acc=%b pend=%h err=%b",
                     o.stall, o.accept, o.pending, o.err, e.stall, e.accept, e.pending, e.err);
         end
      end
   endtask

   task automatic test_saturation();
      resp_t e, o;
      for (int i = 0; i < 4; i++) cycle(.iv(1'b1), .we(1'b1), .wa(7));
      cycle(.iv(1'b1), .we(1'b1), .wa(7), .wv(1'b1), .wwa(7));
      cycle(.iv(1'b1), .ra1(7), .u1(1'b1));
      cycle(.wv(1'b1), .wwa(7), .kv(1'b1), .kwa(7));
      cycle(.iv(1'b1), .ra2(7), .u2(1'b1), .wv(1'b1), .wwa(7));
      cycle(.iv(1'b1), .ra1(7), .u1(1'b1));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL saturation: got stall=%b acc=%b pend=%h err=%b, want stall=%b acc=%b pend=%h err=%b",
                     o.stall, o.accept, o.pending, o.err, e.stall, e.accept, e.pending, e.err);
         end
      end
   endtask

   task automatic test_xzr();
      resp_t e, o;
      for (int i = 0; i < 5; i++)
         cycle(.iv(1'b1), .ra1(31), .u1(1'b1), .ra2(31), .u2(1'b1), .we(1'b1), .wa(31));
      cycle(.wv(1'b1), .wwa(31), .kv(1'b1), .kwa(31));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL xzr: got stall=%b acc=%b pend=%h err=%b, want stall=%b acc=%b pend=%h err=%b",
                     o.stall, o.accept, o.pending, o.err, e.stall, e.accept, e.pending, e.err);
         end
      end
   endtask

   task automatic test_kill();
      resp_t e, o;
      cycle(.iv(1'b1), .we(1'b1), .wa(9));
      cycle(.kv(1'b1), .kwa(9));
      cycle(.wv(1'b1), .wwa(9));
      cycle();
      cycle(.iv(1'b1), .we(1'b1), .wa(9));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL kill_err: got stall=%b acc=%b pend=%h err=%b, want stall=%b acc=%b pend=%h err=%b",
                     o.stall, o.accept, o.pending, o.err, e.stall, e.accept, e.pending, e.err);
         end
      end
      vectors++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL err_sticky: got err=%b, want 1", err);
      end
   endtask

   task automatic test_reset_mid();
      resp_t e, o;
      cycle(.iv(1'b1), .we(1'b1), .wa(4));
      cycle(.iv(1'b1), .we(1'b1), .wa(4));
      cycle(.rst(1'b1), .iv(1'b1), .ra1(4), .u1(1'b1), .we(1'b1), .wa(4));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL reset_mid: got stall=%b acc=%b pend=%h err=%b, want stall=%b acc=%b pend=%h err=%b",
                     o.stall, o.accept, o.pending, o.err, e.stall, e.accept, e.pending, e.err);
         end
      end
      vectors++;
      if (pending !== 32'h0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_clear: got pend=%h err=%b, want pend=00000000 err=0", pending, err);
      end
   endtask

   function automatic int rnd_reg();
      int p;
      p = int'($urandom_range(0, 4));
      return (p == 4) ? 31 : p;
   endfunction

   task automatic test_back_to_back();
      resp_t e, o;
      cycle(.rst(1'b1));
      for (int i = 0; i < 300; i++)
         cycle(.iv(1'($urandom_range(0, 1))),
               .ra1(rnd_reg()), .u1(1'($urandom_range(0, 1))),
               .ra2(rnd_reg()), .u2(1'($urandom_range(0, 1))),
               .we(1'($urandom_range(0, 1))), .wa(rnd_reg()),
               .wv(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0), .wwa(rnd_reg()),
               .kv(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0), .kwa(rnd_reg()));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL back_to_back: got stall=%b acc=%b pend=%h err=%b, want stall=%b acc=%b pend=%h err=%b",
                     o.stall, o.accept, o.pending, o.err, e.stall, e.accept, e.pending, e.err);
         end
      end
   endtask

   initial begin
      reset = 1'b1; issue_valid = 1'b0;
      issue_ra1 = 5'd0; issue_use1 = 1'b0; issue_ra2 = 5'd0; issue_use2 = 1'b0;
      issue_we = 1'b0; issue_wa = 5'd0;
      wb_valid = 1'b0; wb_wa = 5'd0; kill_valid = 1'b0; kill_wa = 5'd0;
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_err = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      test_reset();
      test_raw();
      test_saturation();
      test_xzr();
      test_kill();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
